// File: rtl/mat_pkg.sv
// mat_pkg: shared definitions for the matrix memory reader.
//   - state_t and the ST_* state encodings (IDLE, RUN, DRAIN, DONE)
//   - MAT_M_DEF / MAT_N_DEF: default matrix shape used as parameter defaults
//   - cnt_w(): counter width for a dimension, never less than 1 bit
//   - elem_count(): number of elements in an M x N matrix
package mat_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned MAT_M_DEF = 8;
  localparam int unsigned MAT_N_DEF = 8;

  // $clog2(1) is 0, which would give a zero-width counter
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned elem_count(input int unsigned m, input int unsigned n);
    return m * n;
  endfunction

endpackage

// File: rtl/mat_addr_gen.sv
// mat_addr_gen: row/column counters and the incremental read address.
// Optional feature macro: MAT_READER_TRANSPOSE_EN (adds the transpose input and
// column-major stepping; without it only row-major stepping is built).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         restart at base (row = col = 0)
//   step         advance to the next element
//   base         address of element (0,0), taken on load
//   transpose    column-major walk when 1, taken on load (macro only)
//   addr         address of the current element
//   at_last      current element is (M-1, N-1)
module mat_addr_gen
  import mat_pkg::*;
#(
  parameter int unsigned M      = MAT_M_DEF,
  parameter int unsigned N      = MAT_N_DEF,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
`ifdef MAT_READER_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam int unsigned RW = cnt_w(M);
  localparam int unsigned CW = cnt_w(N);

  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              row_end;
  logic              col_end;
  logic [RW-1:0]     rm_row;
  logic [CW-1:0]     rm_col;

  assign row_end = (row_q == RW'(M - 1));
  assign col_end = (col_q == CW'(N - 1));
  assign at_last = row_end && col_end;
  assign addr    = addr_q;

  // Row-major successor; the row counter may wrap past M-1 after the final
  // element, which is harmless because nothing steps after that.
  always_comb begin
    rm_row = row_q;
    rm_col = col_q + CW'(1);
    if (col_end) begin
      rm_row = row_q + RW'(1);
      rm_col = '0;
    end
  end

`ifdef MAT_READER_TRANSPOSE_EN
  logic              tr_q;
  // Address of the top of the current column, so the next column can start
  // at base + col + 1 without a multiplier.
  logic [ADDR_W-1:0] col_base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_q       <= 1'b0;
      col_base_q <= '0;
    end else if (load) begin
      tr_q       <= transpose;
      col_base_q <= base;
    end else if (step && tr_q && row_end) begin
      col_base_q <= col_base_q + ADDR_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (load) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= base;
    end else if (step) begin
`ifdef MAT_READER_TRANSPOSE_EN
      if (tr_q) begin
        if (row_end) begin
          row_q  <= '0;
          col_q  <= col_q + CW'(1);
          addr_q <= col_base_q + ADDR_W'(1);
        end else begin
          row_q  <= row_q + RW'(1);
          addr_q <= addr_q + ADDR_W'(N);
        end
      end else begin
        row_q  <= rm_row;
        col_q  <= rm_col;
        addr_q <= addr_q + ADDR_W'(1);
      end
`else
      row_q  <= rm_row;
      col_q  <= rm_col;
      addr_q <= addr_q + ADDR_W'(1);
`endif
    end
  end

endmodule

// File: rtl/mat_mem_reader.sv
// mat_mem_reader: walks an M x N matrix in block RAM starting at base_addr,
// issues one read per element and streams elements out over valid/ready.
// Never writes memory. Optional feature macro: MAT_READER_TRANSPOSE_EN.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr         begin a transfer from base_addr (only when idle)
//   transpose                column-major walk (macro only)
//   busy, done               transfer in progress / one-cycle completion pulse
//   mem_ram_en, mem_read_en  memory read strobe
//   mem_write_en             tied low
//   mem_addr, mem_data       memory address / registered read data
//   out_data, out_valid      element stream
//   out_ready, out_last      downstream accept / final element marker
module mat_mem_reader
  import mat_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned M      = MAT_M_DEF,
  parameter int unsigned N      = MAT_N_DEF,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef MAT_READER_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_ram_en,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DW-1:0]     mem_data,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_t            state_q;
  state_t            state_d;
  logic              out_valid_q;
  logic              out_last_q;
  logic              issue;
  logic              load;
  logic              hs;
  logic              at_last;
  logic [ADDR_W-1:0] cur_addr;

  // A new read is only issued when the output register is free or being
  // drained this cycle, which is what keeps out_data stable under stall.
  assign issue = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign load  = (state_q == ST_IDLE) && start;
  assign hs    = out_valid_q && out_ready;

  mat_addr_gen #(
    .M      (M),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (issue),
    .base      (base_addr),
`ifdef MAT_READER_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .addr      (cur_addr),
    .at_last   (at_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue && at_last) state_d = ST_DRAIN;
      ST_DRAIN: if (hs && out_last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        out_valid_q <= 1'b1;
        out_last_q  <= at_last;
      end else if (hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign mem_ram_en   = issue;
  assign mem_read_en  = issue;
  assign mem_write_en = 1'b0;
  assign mem_addr     = issue ? cur_addr : '0;
  assign out_data     = mem_data;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;

endmodule

// File: tb/tb_mat_mem_reader.sv
// Bench for mat_mem_reader: a 2x3 instance exercised through a table of
// transfers (row-major order, backpressure, address wrap, start while busy,
// random ready), a reset-mid-transfer sequence, and a 1x1 instance checked
// cycle by cycle from a table.
module tb_mat_mem_reader;

  localparam int M  = 2;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, mem_ram_en, mem_read_en, mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;
`ifdef MAT_READER_TRANSPOSE_EN
  logic          transpose = 1'b0;
  logic          tie0 = 1'b0;
`endif

  logic          start1 = 1'b0;
  logic [AW-1:0] base1 = '0;
  logic          busy1, done1, ram_en1, read_en1, write_en1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] mem_q1 = '0;
  logic [DW-1:0] data1;
  logic          valid1, last1;
  logic          ready1 = 1'b1;

  logic [DW-1:0] mem [256];

  always @(posedge clk) if (mem_ram_en && mem_read_en) mem_q <= mem[mem_addr];
  always @(posedge clk) if (ram_en1 && read_en1) mem_q1 <= mem[addr1];

  mat_mem_reader #(.DW(DW), .M(M), .N(N), .ADDR_W(AW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
`ifdef MAT_READER_TRANSPOSE_EN
    .transpose    (transpose),
`endif
    .busy         (busy),
    .done         (done),
    .mem_ram_en   (mem_ram_en),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_q),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  mat_mem_reader #(.DW(DW), .M(1), .N(1), .ADDR_W(AW)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .start        (start1),
    .base_addr    (base1),
`ifdef MAT_READER_TRANSPOSE_EN
    .transpose    (tie0),
`endif
    .busy         (busy1),
    .done         (done1),
    .mem_ram_en   (ram_en1),
    .mem_read_en  (read_en1),
    .mem_write_en (write_en1),
    .mem_addr     (addr1),
    .mem_data     (mem_q1),
    .out_data     (data1),
    .out_valid    (valid1),
    .out_ready    (ready1),
    .out_last     (last1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transfer on the 2x3 instance. Expected addresses come from the matrix
  // layout; outputs are sampled 1 time unit after the negedge where inputs
  // change, so the next posedge sees exactly what was sampled.
  task automatic run_xfer(input logic [7:0] base, input bit tr, input int mode,
                          input int junk_at, output logic [7:0] first_d,
                          output logic [7:0] last_d);
    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic [7:0] held_d;
    logic       held_l;
    bit         stall = 0;
    int         last_k = -1;
    int         first_k = -1;
    int         nhs = 0;
    first_d = '0;
    last_d  = '0;
    if (tr) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < M; r++) exp_q.push_back(base + 8'(r * N + c));
    end else begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++) exp_q.push_back(base + 8'(r * N + c));
    end
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    out_ready = 1'b1;
`ifdef MAT_READER_TRANSPOSE_EN
    transpose = tr;
`endif
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      base_addr = base;
      if (k == junk_at) begin
        start = 1'b1;
        base_addr = base ^ 8'h5a;
`ifdef MAT_READER_TRANSPOSE_EN
        transpose = ~tr;
`endif
      end
      case (mode)
        1:       out_ready = ((k - 1) % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      #1;
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_d);
        chk("hold_last", out_last, held_l);
      end
      stall  = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (stall) chk("stall_no_read", mem_read_en, 0);
      if (out_valid && first_k < 0) begin
        first_k = k;
        chk("first_valid_latency", k, 2);
      end
      chk("busy", busy, (last_k < 0 || k <= last_k));
      chk("done", done, (last_k >= 0 && k == last_k + 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_element: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, mem[e]);
          chk("last", out_last, exp_q.size() == 0);
          if (nhs == 0) first_d = out_data;
          nhs++;
          if (exp_q.size() == 0) begin
            last_k = k;
            last_d = out_data;
          end
        end
      end
      if (last_k >= 0 && k == last_k + 4) break;
    end
    if (last_k < 0) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: got %0d elements expected %0d", nhs, M * N);
    end
    chk("write_en", mem_write_en, 0);
    chk("all_consumed", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  typedef struct {
    logic [7:0] base;
    int         mode;
    int         junk_at;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } xfer_t;

  typedef struct {
    logic busy;
    logic ren;
    logic valid;
    logic last;
    logic done;
  } cyc_t;

  initial begin
    xfer_t      xt[6];
    cyc_t       ct[4];
    logic [7:0] rb;
    logic [7:0] f, l;
    int         nhs;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    xt[0] = '{8'h10, 0, -1, 8'h10, 8'h15};
    xt[1] = '{8'h10, 1, -1, 8'h10, 8'h15};
    xt[2] = '{8'hfe, 0, -1, 8'hfe, 8'h03};
    xt[3] = '{8'h40, 0,  4, 8'h40, 8'h45};
    rb = 8'($urandom);
    xt[4] = '{rb, 2, -1, rb, rb + 8'd5};
    rb = 8'($urandom);
    xt[5] = '{rb, 2,  3, rb, rb + 8'd5};

    ct[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ct[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ct[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ct[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ram_en", mem_ram_en, 0);
    chk("rst_read_en", mem_read_en, 0);
    chk("rst_addr", mem_addr, 0);

    foreach (xt[i]) begin
      run_xfer(xt[i].base, 1'b0, xt[i].mode, xt[i].junk_at, f, l);
      chk($sformatf("xfer%0d_first", i), f, xt[i].exp_first);
      chk($sformatf("xfer%0d_last", i), l, xt[i].exp_last);
    end

    // Reset after three elements: everything drops, no done, then a clean restart
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h30;
    out_ready = 1'b1;
    nhs = 0;
    for (int k = 0; k < 50 && nhs < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) nhs++;
    end
    chk("pre_reset_handshakes", nhs, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_ram_en", mem_ram_en, 0);
    chk("mid_rst_read_en", mem_read_en, 0);
    chk("mid_rst_addr", mem_addr, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", done, 0);
      chk("post_rst_idle", busy, 0);
    end
    run_xfer(8'h20, 1'b0, 0, -1, f, l);
    chk("restart_first", f, 8'h20);
    chk("restart_last", l, 8'h25);

`ifdef MAT_READER_TRANSPOSE_EN
    run_xfer(8'h00, 1'b1, 0, -1, f, l);
    chk("transpose_first", f, 8'h00);
    chk("transpose_last", l, 8'h05);
    run_xfer(8'h50, 1'b1, 1, 3, f, l);
    chk("transpose_bp_last", l, 8'h55);
`endif

    // 1x1 matrix, cycle by cycle
    @(negedge clk);
    start1 = 1'b1;
    base1 = 8'h42;
    #1;
    chk("d1_idle_busy", busy1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      chk($sformatf("d1_c%0d_busy", k + 1), busy1, ct[k].busy);
      chk($sformatf("d1_c%0d_read_en", k + 1), read_en1, ct[k].ren);
      chk($sformatf("d1_c%0d_valid", k + 1), valid1, ct[k].valid);
      chk($sformatf("d1_c%0d_last", k + 1), last1, ct[k].last);
      chk($sformatf("d1_c%0d_done", k + 1), done1, ct[k].done);
      if (k == 0) chk("d1_addr", addr1, 8'h42);
      if (k == 1) chk("d1_data", data1, 8'h42);
    end
    chk("d1_write_en", write_en1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
